best_memory_ctrl: RTL and testbench
===================================

# best_memory_ctrl

Sequencer for the 256-entry best-track circular buffer, a 34-bit block RAM with a write pointer, a registered read address, a back pointer and a full flag. It writes one entry per bunch crossing while running, queues L1A-triggered readout windows, and streams each window out over a valid/ready handshake. It also drives the back pointer and window size the memory uses for its full computation. It sits between the trigger/readout logic and the memory instance in the ALCT readout path.

## Interface
Parameters:
- AW, 8, memory address width (256 entries)
- DW, 34, memory data width
- QDEPTH, 4, pending-L1A queue depth (power of 2)

Ports:
- clk  in  1  bunch-crossing clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- run  in  1  enables per-cycle writing
- l1a  in  1  L1A accept pulse, one cycle
- l1a_delay  in  AW  distance in entries from the write pointer back to the window start
- winsize  in  AW  window length in entries
- adw  out  AW  memory write address
- we  out  1  memory write enable
- adr  out  AW  memory read address (combinational next-address)
- adb  out  AW  memory back pointer
- wblock  out  AW  memory write-block size; equals winsize
- full  in  1  memory full flag
- dr  in  DW  memory read data
- dout  out  DW  readout data; equals dr
- dout_valid  out  1  readout word valid
- dout_ready  in  1  downstream accepts word
- dout_first / dout_last  out  1  first / last word of window, qualified by dout_valid
- busy  out  1  window streaming or queue non-empty
- ovf  out  1  sticky: a write was suppressed by full
- l1a_lost  out  1  sticky: an L1A was dropped because the queue was full

## Operation
Write side:
- we = run & !full, combinational.
- adw increments by 1, mod 256, on every cycle with we=1. It holds otherwise.
- When run=1 and full=1, we is suppressed, adw holds and ovf is set.

L1A queue:
- On l1a=1, push start = adw − l1a_delay (mod 256).
- If count==QDEPTH and no pop occurs in the same cycle, the L1A is dropped and l1a_lost is set.
- A push and a pop in the same cycle leave count unchanged; at count==QDEPTH the push is accepted.

Read FSM, states IDLE and STREAM:
- IDLE: if the queue is non-empty, pop the head, load rd_ptr=start and rem=winsize−1, drive adr=start, and go to STREAM.
  - A popped entry with winsize==0 is discarded and the FSM stays in IDLE.
  - winsize is sampled at pop.
- STREAM: dout_valid=1 and dout=dr=mem[rd_ptr]. dout_first=1 on the first word; dout_last=1 when rem==0.
  - Handshake with rem≠0: rd_ptr+1 (mod 256), rem−1.
  - Handshake with rem==0: return to IDLE. The next pop happens the following cycle, so there is one idle cycle between windows.
  - No handshake: rd_ptr, rem and dout hold.
- adr = rd_ptr advanced by the current handshake (or the new start at pop). Memory read data is therefore valid the cycle after the address is driven, with no bubbles inside a window.

Back pointer:
- adb is combinational from registers and selects the oldest retained address, in priority order:
  - window start of the active window (STREAM)
  - else the queue head start
  - else adw − l1a_delay
- wblock = winsize.
- The memory declares full when (adb−adw) mod 256 ≤ wblock+10 and adb≠adw.

Configuration rule: winsize ≤ l1a_delay ≤ 255−winsize−10. Behaviour outside this range is unspecified.

## Timing
Reset values (rst_n=0 at an edge):
- adw=0, rd_ptr=0, rem=0, queue empty, FSM=IDLE.
- dout_valid=0, dout_first=0, dout_last=0, busy=0, ovf=0, l1a_lost=0.
- we=run&!full. While rst_n=0, we=0 and l1a is ignored.
- adb = 0 − l1a_delay.

Latency:
- l1a at cycle t: push at edge t.
- Pop in IDLE at t+1, with adr=start.
- First dout_valid at t+2.

Other cycle rules:
- A window of N words with dout_ready held high takes N consecutive valid cycles.
- Reset mid-STREAM: window abandoned; dout_valid=0 from the cycle after the reset edge.
- adw wraps 255→0 and rd_ptr wraps 255→0 with no gap.

## Test plan
- Reset; run=1 for 100 cycles, l1a_delay=20, winsize=4 → adw=100, we=1 throughout, dout_valid never set, adb=80.
- l1a at adw=100 → dout_valid from 2 cycles later for 4 cycles with data of addresses 80,81,82,83; dout_first on 80, dout_last on 83; busy drops after the last word.
- Same as above with dout_ready=0 for 3 cycles on the second word → dout holds address 81 data and adr holds 81; exactly 4 words delivered, no duplicates.
- winsize=8, l1a on 6 consecutive cycles → 5 windows delivered (40 words, starts at consecutive addresses), l1a_lost=1.
- l1a at adw=100 (delay 20, winsize 4), dout_ready=0, run=1 → adw stops at 66, we=0, ovf=1. Raising dout_ready completes the window and writing resumes.
- rst_n low for one cycle mid-STREAM, with write wraparound from adw=250 → all outputs at reset values the next cycle; a new L1A after reset streams correctly across address 255→0.

Source files
------------

// File: rtl/best_memory_ctrl_if.sv
// Signal bundle between best_memory_ctrl, the best-track memory and the readout consumer.
// The controller is the master: it drives the memory addresses and the readout stream.
interface best_memory_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 34
);
    logic          run;
    logic          l1a;
    logic [AW-1:0] l1a_delay;
    logic [AW-1:0] winsize;
    logic [AW-1:0] adw;
    logic          we;
    logic [AW-1:0] adr;
    logic [AW-1:0] adb;
    logic [AW-1:0] wblock;
    logic          full;
    logic [DW-1:0] dr;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_first;
    logic          dout_last;
    logic          busy;
    logic          ovf;
    logic          l1a_lost;

    modport master (
        input  run, l1a, l1a_delay, winsize, full, dr, dout_ready,
        output adw, we, adr, adb, wblock, dout, dout_valid, dout_first, dout_last,
               busy, ovf, l1a_lost
    );

    modport slave (
        output run, l1a, l1a_delay, winsize, full, dr, dout_ready,
        input  adw, we, adr, adb, wblock, dout, dout_valid, dout_first, dout_last,
               busy, ovf, l1a_lost
    );
endinterface

// File: rtl/best_memory_ctrl.sv
// Best-track circular buffer sequencer: per-crossing writes, L1A window queue,
// and valid/ready streaming of each window with back-pointer protection.
module best_memory_ctrl #(
    parameter int AW     = 8,
    parameter int DW     = 34,
    parameter int QDEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    best_memory_ctrl_if.master  bus
);
    localparam int QW = $clog2(QDEPTH);
    localparam logic [QW:0]   QFULL  = (QW+1)'(QDEPTH);
    localparam logic [QW:0]   CONE   = (QW+1)'(1);
    localparam logic [QW-1:0] PONE   = QW'(1);
    localparam logic [AW-1:0] AONE   = AW'(1);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] adw_q, adw_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [AW-1:0] start_q, start_d;
    logic          first_q, first_d;
    logic [AW-1:0] queue_q [QDEPTH];
    logic [QW-1:0] head_q, head_d;
    logic [QW-1:0] tail_q, tail_d;
    logic [QW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          lost_q, lost_d;

    logic          we;
    logic          pop;
    logic          push;
    logic          hs;
    logic          streaming;
    logic [AW-1:0] head_start;
    logic [AW-1:0] push_start;

    always_comb begin
        streaming  = (state_q == STREAM);
        we         = rst_n & bus.run & ~bus.full;
        hs         = streaming & bus.dout_ready;
        pop        = (state_q == IDLE) & (count_q != '0);
        // A pop frees a slot in the same cycle, so a push at full depth still lands.
        push       = rst_n & bus.l1a & ((count_q != QFULL) | pop);
        head_start = queue_q[head_q];
        push_start = adw_q - bus.l1a_delay;
    end

    always_comb begin
        adw_d  = we ? adw_q + AONE : adw_q;
        ovf_d  = ovf_q | (rst_n & bus.run & bus.full);
        lost_d = lost_q | (rst_n & bus.l1a & ~push);
        head_d = pop ? head_q + PONE : head_q;
        tail_d = push ? tail_q + PONE : tail_q;
        count_d = count_q;
        if (push & ~pop) begin
            count_d = count_q + CONE;
        end else if (pop & ~push) begin
            count_d = count_q - CONE;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        rem_d    = rem_q;
        start_d  = start_q;
        first_d  = first_q;
        bus.adr  = rd_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    bus.adr = head_start;
                    if (bus.winsize != '0) begin
                        state_d  = STREAM;
                        rd_ptr_d = head_start;
                        start_d  = head_start;
                        rem_d    = bus.winsize - AONE;
                        first_d  = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (hs) begin
                    // Advance the read address now so the next word arrives without a bubble.
                    bus.adr = rd_ptr_q + AONE;
                    first_d = 1'b0;
                    if (rem_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + AONE;
                        rem_d    = rem_q - AONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            adw_q    <= '0;
            rd_ptr_q <= '0;
            rem_q    <= '0;
            start_q  <= '0;
            first_q  <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            adw_q    <= adw_d;
            rd_ptr_q <= rd_ptr_d;
            rem_q    <= rem_d;
            start_q  <= start_d;
            first_q  <= first_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            lost_q   <= lost_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            queue_q[tail_q] <= push_start;
        end
    end

    always_comb begin
        bus.adw        = adw_q;
        bus.we         = we;
        bus.wblock     = bus.winsize;
        bus.dout       = bus.dr;
        bus.dout_valid = streaming;
        bus.dout_first = streaming & first_q;
        bus.dout_last  = streaming & (rem_q == '0);
        bus.busy       = streaming | (count_q != '0);
        bus.ovf        = ovf_q;
        bus.l1a_lost   = lost_q;
        // Oldest address still needed: active window, then queued window, then the next L1A's start.
        if (streaming) begin
            bus.adb = start_q;
        end else if (count_q != '0) begin
            bus.adb = head_start;
        end else begin
            bus.adb = adw_q - bus.l1a_delay;
        end
    end
endmodule

// File: tb/tb_best_memory_ctrl.sv
// Bench for best_memory_ctrl: a memory image plus a window-level model of the
// L1A queue and readout, compared against the DUT every cycle.
module tb_best_memory_ctrl;
    localparam int AW = 8;
    localparam int DW = 34;
    localparam int QDEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    best_memory_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    best_memory_ctrl #(.AW(AW), .DW(DW), .QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] wdata;
    logic [DW-1:0] mem    [256];
    logic [DW-1:0] shadow [256];

    // Window-level model state
    int m_adw;
    int pend[$];
    bit act;
    int cur_start;
    int cur_ws;
    int idx;
    bit m_ovf;
    bit m_lost;
    bit live = 1'b0;
    int dut_words = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    function automatic int exp_adb();
        if (act) return cur_start;
        if (pend.size() > 0) return pend[0];
        return (m_adw - int'(bus.l1a_delay)) & 255;
    endfunction

    function automatic bit calc_full();
        int adb;
        int d;
        adb = exp_adb();
        d = (adb - m_adw) & 255;
        return (d <= int'(bus.winsize) + 10) && (adb != m_adw);
    endfunction

    task automatic model_step();
        int old_adw;
        int s;
        bit pop;
        if (!rst_n) begin
            m_adw = 0;
            pend.delete();
            act = 1'b0;
            idx = 0;
            m_ovf = 1'b0;
            m_lost = 1'b0;
            live = 1'b1;
            return;
        end
        if (!live) return;
        old_adw = m_adw;
        if (bus.run && !bus.full) begin
            shadow[m_adw] = wdata;
            m_adw = (m_adw + 1) & 255;
        end
        if (bus.run && bus.full) m_ovf = 1'b1;
        pop = !act && (pend.size() > 0);
        if (act && bus.dout_ready) begin
            if (idx == cur_ws - 1) act = 1'b0;
            else idx++;
        end
        if (pop) begin
            s = pend.pop_front();
            if (bus.winsize != 0) begin
                act = 1'b1;
                cur_start = s;
                cur_ws = int'(bus.winsize);
                idx = 0;
            end
        end
        if (bus.l1a) begin
            if (pend.size() < QDEPTH) pend.push_back((old_adw - int'(bus.l1a_delay)) & 255);
            else m_lost = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Memory: synchronous write at adw, registered read at adr.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        bus.dr = '0;
        forever begin
            @(posedge clk);
            if (bus.we) mem[bus.adw] <= wdata;
            bus.dr <= mem[bus.adr];
        end
    end

    // Memory full flag, derived from the model's back pointer.
    initial begin
        bus.full = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.full = live && calc_full();
        end
    end

    initial begin
        int a;
        forever begin
            @(negedge clk);
            if (live) begin
                chk("we", bus.we, rst_n && bus.run && !bus.full);
                chk("adw", bus.adw, m_adw);
                chk("adb", bus.adb, exp_adb());
                chk("wblock", bus.wblock, bus.winsize);
                chk("dout_valid", bus.dout_valid, act);
                chk("busy", bus.busy, act || (pend.size() > 0));
                chk("ovf", bus.ovf, m_ovf);
                chk("l1a_lost", bus.l1a_lost, m_lost);
                if (act) begin
                    a = (cur_start + idx) & 255;
                    chk("dout", bus.dout, shadow[a]);
                    chk("dout_first", bus.dout_first, idx == 0);
                    chk("dout_last", bus.dout_last, idx == cur_ws - 1);
                    if (rst_n) chk("adr", bus.adr, (cur_start + idx + (bus.dout_ready ? 1 : 0)) & 255);
                end else begin
                    chk("dout_first_idle", bus.dout_first, 1'b0);
                    chk("dout_last_idle", bus.dout_last, 1'b0);
                    if (rst_n && pend.size() > 0) chk("adr_pop", bus.adr, pend[0]);
                end
                if (rst_n && bus.dout_valid && bus.dout_ready) dut_words++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wdata = {2'($urandom), 32'($urandom)};
    endtask

    task automatic reset_fill(input int dly, input int ws, input int n);
        rst_n = 1'b0;
        bus.run = 1'b0;
        bus.l1a = 1'b0;
        bus.dout_ready = 1'b1;
        bus.l1a_delay = AW'(dly);
        bus.winsize = AW'(ws);
        tick();
        rst_n = 1'b1;
        bus.run = 1'b1;
        repeat (n) tick();
    endtask

    task automatic wait_idle(input int lim);
        int i;
        i = 0;
        while (bus.busy && i < lim) begin
            tick();
            i++;
        end
        chk("idle_timeout", bus.busy, 1'b0);
    endtask

    initial begin
        int w0;
        int ws;
        int dly;
        rst_n = 1'b0;
        bus.run = 1'b0;
        bus.l1a = 1'b0;
        bus.dout_ready = 1'b1;
        bus.l1a_delay = 8'd20;
        bus.winsize = 8'd4;
        wdata = '0;

        // Fill 100 entries, then a single 4-word window from address 80.
        reset_fill(20, 4, 100);
        @(negedge clk);
        chk("fill_adw", bus.adw, 100);
        chk("fill_model_adw", m_adw, 100);
        chk("fill_adb", bus.adb, 80);
        chk("fill_no_words", dut_words, 0);
        bus.l1a = 1'b1;
        tick();
        bus.l1a = 1'b0;
        @(negedge clk);
        chk("lat_valid_t1", bus.dout_valid, 1'b0);
        chk("lat_adr_pop", bus.adr, 80);
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("win_valid", bus.dout_valid, 1'b1);
            chk("win_data", bus.dout, shadow[80 + k]);
            chk("win_first", bus.dout_first, k == 0);
            chk("win_last", bus.dout_last, k == 3);
            tick();
        end
        @(negedge clk);
        chk("win_busy_drop", bus.busy, 1'b0);

        // Stall on the second word.
        reset_fill(20, 4, 100);
        w0 = dut_words;
        bus.l1a = 1'b1;
        tick();
        bus.l1a = 1'b0;
        tick();
        tick();
        bus.dout_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_adr", bus.adr, 81);
            chk("stall_data", bus.dout, shadow[81]);
            tick();
        end
        bus.dout_ready = 1'b1;
        wait_idle(20);
        chk("stall_words", dut_words - w0, 4);

        // Six back-to-back L1As into a 4-deep queue.
        reset_fill(20, 8, 100);
        w0 = dut_words;
        bus.l1a = 1'b1;
        repeat (6) tick();
        bus.l1a = 1'b0;
        wait_idle(200);
        chk("burst_lost", bus.l1a_lost, 1'b1);
        chk("burst_words", dut_words - w0, 40);

        // Back-pressure until the writer reaches the protected window.
        reset_fill(20, 4, 100);
        bus.dout_ready = 1'b0;
        bus.l1a = 1'b1;
        tick();
        bus.l1a = 1'b0;
        repeat (300) tick();
        @(negedge clk);
        chk("full_adw", bus.adw, 66);
        chk("full_we", bus.we, 1'b0);
        chk("full_ovf", bus.ovf, 1'b1);
        bus.dout_ready = 1'b1;
        wait_idle(20);
        repeat (3) tick();
        @(negedge clk);
        chk("resume_we", bus.we, 1'b1);

        // Reset mid-window while the writer wraps, then a window across 255->0.
        reset_fill(20, 4, 250);
        bus.l1a = 1'b1;
        tick();
        bus.l1a = 1'b0;
        repeat (2) tick();
        bus.dout_ready = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.dout_ready = 1'b1;
        @(negedge clk);
        chk("rst_valid", bus.dout_valid, 1'b0);
        chk("rst_adw", bus.adw, 0);
        chk("rst_busy", bus.busy, 1'b0);
        bus.l1a_delay = 8'd5;
        repeat (3) tick();
        w0 = dut_words;
        bus.l1a = 1'b1;
        tick();
        bus.l1a = 1'b0;
        @(negedge clk);
        chk("wrap_adr_pop", bus.adr, 254);
        wait_idle(20);
        chk("wrap_words", dut_words - w0, 4);

        // Randomized traffic with a fixed configuration per episode.
        for (int ep = 0; ep < 8; ep++) begin
            bus.l1a = 1'b0;
            bus.dout_ready = 1'b1;
            wait_idle(600);
            ws = $urandom_range(0, 24);
            dly = $urandom_range(ws, 245 - ws);
            bus.winsize = AW'(ws);
            bus.l1a_delay = AW'(dly);
            tick();
            repeat (400) begin
                bus.run = ($urandom % 8) != 0;
                bus.l1a = ($urandom % 12) == 0;
                bus.dout_ready = ($urandom % 4) != 0;
                tick();
            end
        end
        bus.l1a = 1'b0;
        bus.dout_ready = 1'b1;
        wait_idle(600);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
